popcount_ternary_acc: RTL

POPCOUNT_TERNARY_ACC -- requirements
Module: popcount_ternary_acc

---
 rtl/popcount_ternary_acc_if.sv | 28 ++
 rtl/popcount_ternary_acc.sv | 108 ++++++++++
 2 files changed

// File: rtl/popcount_ternary_acc_if.sv
// popcount_ternary_acc_if: beat input and result output handshakes of the ternary popcount neuron
interface popcount_ternary_acc_if #(
   parameter int WIDTH = 5,
   parameter int ACC_W = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        in_data;
   logic                    in_neg;
   logic                    in_last;
   logic                    in_approx;
   logic signed [ACC_W:0]   threshold;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W:0]   out_sum;
   logic                    out_act;
   logic [7:0]              out_beats;

   modport master (
      output in_valid, in_data, in_neg, in_last, in_approx, threshold, out_ready,
      input  in_ready, out_valid, out_sum, out_act, out_beats
   );

   modport slave (
      input  in_valid, in_data, in_neg, in_last, in_approx, threshold, out_ready,
      output in_ready, out_valid, out_sum, out_act, out_beats
   );
endinterface

// File: rtl/popcount_ternary_acc.sv
// popcount_ternary_acc: accumulates signed-weight popcounts of activation beats into one thresholded neuron result
module popcount_ternary_acc #(
   parameter int WIDTH       = 5,
   parameter int ACC_W       = 8,
   parameter int APPROX_DROP = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   popcount_ternary_acc_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  live;
   logic                  mode;
   logic                  mode_use;
   logic signed [ACC_W:0] thr;
   logic [ACC_W-1:0]      pos_acc;
   logic [ACC_W-1:0]      neg_acc;
   logic [ACC_W-1:0]      pos_base;
   logic [ACC_W-1:0]      neg_base;
   logic [ACC_W-1:0]      pos_nxt;
   logic [ACC_W-1:0]      neg_nxt;
   logic [ACC_W:0]        add_sum;
   logic [7:0]            beats;
   logic [7:0]            beats_base;
   logic [7:0]            beats_nxt;
   logic [CW-1:0]         pc_exact;
   logic [CW-1:0]         pc_approx;
   logic [CW-1:0]         cnt;
   logic signed [ACC_W:0] diff;
   logic                  fire;
   logic                  first;

   assign fire  = bus.in_valid & bus.in_ready;
   assign first = state == IDLE;
   assign diff  = $signed({1'b0, pos_acc}) - $signed({1'b0, neg_acc});

   // beat popcount; the first beat of a neuron uses the live mode bit, later beats the latched one
   always_comb begin
      pc_exact  = '0;
      pc_approx = CW'(APPROX_DROP / 2);
      for (int i = 0; i < WIDTH; i++) begin
         pc_exact = pc_exact + CW'(bus.in_data[i]);
         if (i >= APPROX_DROP) pc_approx = pc_approx + CW'(bus.in_data[i]);
      end
      mode_use = first ? bus.in_approx : mode;
      cnt      = mode_use ? pc_approx : pc_exact;
   end

   // saturating update of the selected accumulator, starting from zero on the first beat
   always_comb begin
      pos_base   = first ? '0 : pos_acc;
      neg_base   = first ? '0 : neg_acc;
      beats_base = first ? '0 : beats;
      add_sum    = {1'b0, bus.in_neg ? neg_base : pos_base} + (ACC_W + 1)'(cnt);
      pos_nxt    = bus.in_neg ? pos_base : (add_sum[ACC_W] ? '1 : add_sum[ACC_W-1:0]);
      neg_nxt    = bus.in_neg ? (add_sum[ACC_W] ? '1 : add_sum[ACC_W-1:0]) : neg_base;
      beats_nxt  = &beats_base ? beats_base : beats_base + 8'd1;
   end

   // datapath registers; live keeps in_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live    <= 1'b0;
         mode    <= 1'b0;
         thr     <= '0;
         pos_acc <= '0;
         neg_acc <= '0;
         beats   <= '0;
      end else begin
         live <= 1'b1;
         if (fire) begin
            pos_acc <= pos_nxt;
            neg_acc <= neg_nxt;
            beats   <= beats_nxt;
            if (first) begin
               mode <= bus.in_approx;
               thr  <= bus.threshold;
            end
         end
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   end

   // next state: beats advance toward DONE, the result handshake returns to IDLE
   always_comb begin
      state_nxt = state == DONE ? (bus.out_ready ? IDLE : DONE)
                : fire ? (bus.in_last ? DONE : ACCUM) : state;
   end

   // outputs are only meaningful in DONE and forced to zero elsewhere
   always_comb begin
      bus.in_ready  = live & (state != DONE);
      bus.out_valid = state == DONE;
      bus.out_sum   = state == DONE ? diff : '0;
      bus.out_act   = (state == DONE) & (diff >= thr);
      bus.out_beats = state == DONE ? beats : '0;
   end
endmodule
